// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcode, ALU, trap-cause and state encodings
// Used by the control FSM, the datapath and the immediate unit.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM_TO = 2'b10;
  localparam logic [1:0] TRAP_DMEM_TO = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Opcodes the multi-cycle core knows how to sequence.
  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/access_wait_timer.sv
// rtl/access_wait_timer.sv - wait-cycle counter shared by instruction and data accesses
// Ports: clk, rst (async, active-high), clr (zero the count), en (a wait cycle
// is in progress), expired (this wait cycle is the TIMEOUT-th consecutive one).
module access_wait_timer #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 16'd1;
    end
  end

  // count holds the number of earlier wait cycles, so the current cycle is
  // wait number count+1. A ready arriving in that cycle drops en and wins.
  assign expired = en && (count == TIMEOUT - 16'd1);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle control FSM for LD/SD/BEQ
// Inputs : clk, reset (async, active-high), opcode[6:0], alu_zero,
//          imem_ready, dmem_ready.
// Outputs: imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src,
//          alu_op[1:0], reg_write, mem_to_reg (all decoded from state/inputs),
//          trap, trap_cause[1:0] (sticky), instret[CNT_W-1:0].
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd255,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  state_t     state, next_state;
  logic [6:0] op_q;
  logic       trap_q;
  logic [1:0] cause_q;
  logic       retire;
  logic       set_trap;
  logic [1:0] next_cause;
  logic       wait_en;
  logic       wait_expired;

  // Waiting is decided outside the decoder so the timer's expired output does
  // not form a combinational loop back through the next-state logic.
  assign wait_en = ((state == ST_FETCH) && !imem_ready) ||
                   ((state == ST_MEM)   && !dmem_ready);

  access_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (reset),
    .clr     (!wait_en),
    .en      (wait_en),
    .expired (wait_expired)
  );

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    set_trap   = 1'b0;
    next_cause = TRAP_NONE;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;

    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          next_state = ST_DECODE;
        end else if (wait_expired) begin
          set_trap   = 1'b1;
          next_cause = TRAP_IMEM_TO;
          next_state = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (op_supported(opcode)) begin
          next_state = ST_EXEC;
        end else begin
          set_trap   = 1'b1;
          next_cause = TRAP_ILLEGAL;
          next_state = ST_TRAP;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_BRANCH) begin
          alu_op     = ALU_SUB;
          pc_write   = 1'b1;
          pc_src     = alu_zero;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else begin
          alu_src    = 1'b1;
          next_state = ST_MEM;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end else if (wait_expired) begin
          set_trap   = 1'b1;
          next_cause = TRAP_DMEM_TO;
          next_state = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = ST_FETCH;
      end
      ST_TRAP: begin
        next_state = ST_TRAP;
      end
      default: begin
        next_state = ST_FETCH;
      end
    endcase

    // Outputs follow reset immediately so an in-flight access is abandoned
    // without waiting for a clock edge.
    if (reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_FETCH;
      op_q    <= '0;
      trap_q  <= 1'b0;
      cause_q <= TRAP_NONE;
      instret <= '0;
    end else begin
      state <= next_state;
      // Later stages use this copy so IR changes after DECODE are harmless.
      if (state == ST_DECODE) begin
        op_q <= opcode;
      end
      if (set_trap) begin
        trap_q  <= 1'b1;
        cause_q <= next_cause;
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  localparam logic [15:0] T = 16'd12;
  localparam int          CW = 4;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0110011;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          alu_zero, imem_ready, dmem_ready;
  logic          imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic          alu_src, reg_write, mem_to_reg, trap;
  logic [1:0]    alu_op, trap_cause;
  logic [CW-1:0] instret;

  multicycle_ctrl_fsm #(.TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_trap;
    logic          pc_src;
    logic          reg_write;
    int            lat;
    logic [1:0]    cause;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   cycle = 0;
  int   start = 0;
  int   irw = 0;
  logic prev_req = 1'b0;
  logic prev_trap = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    cycle++;
    if (imem_req && !prev_req) begin
      start = cycle;
      irw   = 0;
    end
    if (ir_write) irw++;
    if (pc_write) begin
      if (q.size() == 0) begin
        check("unexpected_retire", 1, 0);
      end else begin
        e = q.pop_front();
        check("retire_kind", {31'd0, e.is_trap}, 0);
        check("pc_src", {31'd0, pc_src}, {31'd0, e.pc_src});
        check("reg_write", {31'd0, reg_write}, {31'd0, e.reg_write});
        check("mem_to_reg", {31'd0, mem_to_reg}, {31'd0, e.reg_write});
        check("latency", cycle - start + 1, e.lat);
        check("ir_write_pulses", irw, 1);
        check("instret_at_retire", {28'd0, instret}, {28'd0, e.cnt});
      end
    end
    if (trap && !prev_trap) begin
      if (q.size() == 0) begin
        check("unexpected_trap", 1, 0);
      end else begin
        e = q.pop_front();
        check("trap_kind", {31'd0, e.is_trap}, 1);
        check("trap_cause", {30'd0, trap_cause}, {30'd0, e.cause});
        check("instret_at_trap", {28'd0, instret}, {28'd0, e.cnt});
      end
    end
    if (trap) begin
      check("enables_in_trap",
            {20'd0, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
             alu_src, alu_op, reg_write, mem_to_reg}, 0);
    end
    prev_req  = imem_req;
    prev_trap = trap;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ret(input logic ps, input logic rw, input int lat);
    exp_t x;
    x.is_trap = 1'b0; x.pc_src = ps; x.reg_write = rw; x.lat = lat;
    x.cause = 2'b00; x.cnt = cnt;
    q.push_back(x);
    cnt = cnt + 1'b1;
  endtask

  task automatic push_trap(input logic [1:0] cause);
    exp_t x;
    x.is_trap = 1'b1; x.pc_src = 1'b0; x.reg_write = 1'b0; x.lat = 0;
    x.cause = cause; x.cnt = cnt;
    q.push_back(x);
  endtask

  // Fetch with iw wait cycles, decode, exec, then dw data wait cycles.
  task automatic instr(input logic [6:0] op, input logic zero, input int iw, input int dw);
    bit mem;
    mem = (op != BEQ);
    push_ret(op == BEQ && zero, op == LD,
             iw + 3 + (mem ? dw + 1 : 0) + (op == LD ? 1 : 0));
    opcode = op;
    alu_zero = zero;
    for (int i = 0; i < iw; i++) begin
      imem_ready = 1'b0; dmem_ready = 1'b1; cyc();
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    opcode = 7'h7f;
    cyc();
    if (mem) begin
      for (int i = 0; i < dw; i++) begin
        dmem_ready = 1'b0; imem_ready = 1'b1; cyc();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b1; cyc();
      dmem_ready = 1'b0;
      if (op == LD) cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc();
    reset = 1'b0;
    cnt = '0;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; alu_zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; cnt = '0;
    repeat (3) cyc();
    check("rst_outputs",
          {20'd0, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_src, alu_op, reg_write, mem_to_reg}, 0);
    check("rst_trap", {29'd0, trap, trap_cause}, 0);
    check("rst_instret", {28'd0, instret}, 0);
    reset = 1'b0;
    #1 check("fetch_after_rst", {31'd0, imem_req}, 1);

    // zero-wait mix
    instr(LD, 1'b0, 0, 0);
    instr(SD, 1'b0, 0, 0);
    instr(BEQ, 1'b1, 0, 0);
    instr(BEQ, 1'b0, 0, 0);
    check("instret_after_mix", {28'd0, instret}, 4);

    // delayed fetch, ready on the last allowed cycles, delayed data
    instr(BEQ, 1'b1, 10, 0);
    instr(BEQ, 1'b0, T - 1, 0);
    instr(SD, 1'b0, 0, T - 1);
    instr(LD, 1'b0, 0, 2);
    check("no_trap_waits", {31'd0, trap}, 0);

    // data timeout on SD
    push_trap(2'b11);
    opcode = SD;
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    cyc();
    for (int i = 0; i < T; i++) begin
      dmem_ready = 1'b0; cyc();
    end
    cyc();
    check("dmem_timeout_trap", {29'd0, trap, trap_cause}, 7);
    do_reset();

    // instruction timeout
    push_trap(2'b10);
    for (int i = 0; i < T; i++) begin
      imem_ready = 1'b0; cyc();
    end
    cyc();
    check("imem_timeout_trap", {29'd0, trap, trap_cause}, 6);
    do_reset();

    // illegal opcode, then readies toggling while trapped
    instr(BEQ, 1'b0, 0, 0);
    push_trap(2'b01);
    opcode = BAD;
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0]; dmem_ready = ~i[0]; cyc();
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    check("illegal_sticky", {29'd0, trap, trap_cause}, 5);
    check("illegal_instret", {28'd0, instret}, 1);
    do_reset();

    // reset in the middle of a load's data access
    instr(BEQ, 1'b0, 0, 0);
    opcode = LD;
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    cyc();
    dmem_ready = 1'b0;
    check("ld_in_mem", {31'd0, dmem_req}, 1);
    cyc();
    reset = 1'b1;
    #1 check("dmem_req_async_drop", {30'd0, dmem_req, imem_req}, 0);
    cyc();
    reset = 1'b0;
    cnt = '0;
    #1;
    check("post_rst_fetch", {31'd0, imem_req}, 1);
    check("post_rst_trap", {31'd0, trap}, 0);
    check("post_rst_instret", {28'd0, instret}, 0);

    // counter wrap
    for (int i = 0; i < 17; i++) begin
      instr(BEQ, i[0], 0, 0);
    end
    check("instret_wrap", {28'd0, instret}, 1);

    repeat (3) cyc();
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
